apb_protocol_monitor: RTL and testbench

Passive, parametrised APB protocol monitor for the I2C controller's register bus: it samples every APB signal on `apb_clk`, tracks each transfer through a SETUP/ACCESS state machine, and reports protocol violations, wait-state timeouts and slave errors as registered flags and counters. It generalises the single prdata-stability check into a full transfer checker with configurable bus widths, timeout and counter widths. It drives nothing on the bus and sits beside the APB slave in both RTL and testbench.

---
 rtl/apb_mon_pkg.sv | 35 +++
 rtl/apb_mon_sat_cnt.sv | 29 ++
 rtl/apb_protocol_monitor.sv | 218 +++++++++++++++++++++
 tb/tb_apb_protocol_monitor.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/apb_mon_pkg.sv
// Shared types for the APB protocol monitor: transfer-tracking states, violation codes
// and the priority encoder that reduces a violation vector to its reported code.
package apb_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    typedef enum logic [2:0] {
        ERR_NONE            = 3'd0,
        ERR_ENABLE_NO_SETUP = 3'd1,
        ERR_NO_ACCESS       = 3'd2,
        ERR_CTRL_CHANGE     = 3'd3,
        ERR_PSEL_DROP       = 3'd4,
        ERR_TIMEOUT         = 3'd5,
        ERR_SLVERR          = 3'd6
    } err_code_e;

    localparam int ERR_NUM = 6;

    // Bit i of the vector carries code i+1; the lowest set code wins.
    function automatic err_code_e prio_encode(input logic [ERR_NUM-1:0] viol);
        err_code_e code;
        code = ERR_NONE;
        for (int i = ERR_NUM - 1; i >= 0; i--) begin
            if (viol[i]) begin
                code = err_code_e'(3'(i + 1));
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/apb_mon_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear dominates increment and the
// count holds at all-ones instead of wrapping.
module apb_mon_sat_cnt #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Count register: reset, clear, saturating increment.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/apb_protocol_monitor.sv
// Passive APB transfer checker: flags protocol violations, timeouts and slave errors.
// Define APB_MON_ASSERT_EN to add concurrent assertions mirroring the violation checks.
module apb_protocol_monitor
    import apb_mon_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  apb_clk,
    input  logic                  reset_n,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic                  pready,
    input  logic                  pslverr,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    input  logic [DATA_WIDTH-1:0] prdata,
    input  logic                  err_clr,
    output logic                  err_valid,
    output logic [2:0]            err_code,
    output logic [ERR_NUM-1:0]    err_sticky,
    output logic [CNT_WIDTH-1:0]  xfer_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic [CNT_WIDTH-1:0]  wait_max
);

    // TIMEOUT must stay below the counter's saturation value to fire exactly once.
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT - 1);

    apb_state_e            state_r, state_nxt_s;
    logic [ADDR_WIDTH-1:0] cap_addr_r;
    logic                  cap_write_r;
    logic [DATA_WIDTH-1:0] cap_wdata_r;
    logic [ERR_NUM-1:0]    viol_s;
    logic                  capture_s, in_access_s, psel_drop_s, complete_s, wait_inc_s, ctrl_diff_s;
    logic [CNT_WIDTH-1:0]  wait_cnt_s;
    logic                  err_valid_r;
    logic [2:0]            err_code_r;
    logic [ERR_NUM-1:0]    err_sticky_r;
    logic [CNT_WIDTH-1:0]  wait_max_r;

    assign ctrl_diff_s = (paddr != cap_addr_r) || (pwrite != cap_write_r) ||
                         (cap_write_r && (pwdata != cap_wdata_r));
    assign complete_s  = in_access_s && pready;
    assign wait_inc_s  = in_access_s && !pready;

    // Transfer decode. SETUP means "this sample must be the first access cycle";
    // ACCESS means "we are in wait states of an already-started access phase".
    always_comb begin
        state_nxt_s = state_r;
        viol_s      = '0;
        capture_s   = 1'b0;
        in_access_s = 1'b0;
        psel_drop_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (penable) begin
                    viol_s[0]   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (psel) begin
                    capture_s   = 1'b1;
                    state_nxt_s = ST_SETUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (psel && penable) begin
                    in_access_s = 1'b1;
                    state_nxt_s = pready ? ST_IDLE : ST_ACCESS;
                end else begin
                    viol_s[1] = 1'b1;
                    if (psel) begin
                        capture_s   = 1'b1;
                        state_nxt_s = ST_SETUP;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
            end
            ST_ACCESS: begin
                if (psel) begin
                    in_access_s = 1'b1;
                    state_nxt_s = pready ? ST_IDLE : ST_ACCESS;
                end else begin
                    psel_drop_s = 1'b1;
                    viol_s[3]   = 1'b1;
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        viol_s[2] = (in_access_s || psel_drop_s) && ctrl_diff_s;
        viol_s[4] = wait_inc_s && (wait_cnt_s == TIMEOUT_CNT);
        viol_s[5] = complete_s && pslverr;
    end

    // State register and setup-phase capture of address/direction/write data.
    always_ff @(posedge apb_clk) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            cap_addr_r  <= '0;
            cap_write_r <= 1'b0;
            cap_wdata_r <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (capture_s) begin
                cap_addr_r  <= paddr;
                cap_write_r <= pwrite;
                cap_wdata_r <= pwdata;
            end else begin
                cap_addr_r  <= cap_addr_r;
                cap_write_r <= cap_write_r;
                cap_wdata_r <= cap_wdata_r;
            end
        end
    end

    // Violation pulse, sticky flags and longest-wait tracking; new sticky bits survive a clear.
    always_ff @(posedge apb_clk) begin
        if (!reset_n) begin
            err_valid_r  <= 1'b0;
            err_code_r   <= 3'd0;
            err_sticky_r <= '0;
            wait_max_r   <= '0;
        end else begin
            err_valid_r  <= |viol_s;
            err_code_r   <= prio_encode(viol_s);
            err_sticky_r <= err_clr ? viol_s : (err_sticky_r | viol_s);
            if (err_clr) begin
                wait_max_r <= '0;
            end else if (complete_s && (wait_cnt_s > wait_max_r)) begin
                wait_max_r <= wait_cnt_s;
            end else begin
                wait_max_r <= wait_max_r;
            end
        end
    end

    apb_mon_sat_cnt #(.WIDTH(CNT_WIDTH)) u_xfer_cnt (
        .clk(apb_clk), .reset_n(reset_n), .clr(err_clr), .inc(complete_s), .count(xfer_cnt)
    );

    apb_mon_sat_cnt #(.WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk(apb_clk), .reset_n(reset_n), .clr(err_clr), .inc(|viol_s), .count(err_cnt)
    );

    // Wait count restarts whenever the current sample is not a wait state.
    apb_mon_sat_cnt #(.WIDTH(CNT_WIDTH)) u_wait_cnt (
        .clk(apb_clk), .reset_n(reset_n), .clr(!wait_inc_s), .inc(wait_inc_s), .count(wait_cnt_s)
    );

    assign err_valid  = err_valid_r;
    assign err_code   = err_code_r;
    assign err_sticky = err_sticky_r;
    assign wait_max   = wait_max_r;

`ifdef APB_MON_ASSERT_EN
    apb_mon_checker #(.DATA_WIDTH(DATA_WIDTH), .CNT_WIDTH(CNT_WIDTH), .TIMEOUT_CNT(TIMEOUT_CNT)) u_checker (
        .apb_clk(apb_clk), .reset_n(reset_n), .psel(psel), .penable(penable), .pready(pready),
        .prdata(prdata), .state(state_r), .in_access(in_access_s), .psel_drop(psel_drop_s),
        .ctrl_diff(ctrl_diff_s), .wait_cnt(wait_cnt_s)
    );
`else
    logic unused_prdata_s;
    assign unused_prdata_s = ^prdata;
`endif

endmodule

`ifdef APB_MON_ASSERT_EN
// Concurrent assertions mirroring violation codes 1-5 plus read-data stability.
module apb_mon_checker
    import apb_mon_pkg::*;
#(
    parameter int                   DATA_WIDTH  = 8,
    parameter int                   CNT_WIDTH   = 16,
    parameter logic [CNT_WIDTH-1:0] TIMEOUT_CNT = '0
) (
    input logic                  apb_clk,
    input logic                  reset_n,
    input logic                  psel,
    input logic                  penable,
    input logic                  pready,
    input logic [DATA_WIDTH-1:0] prdata,
    input apb_state_e            state,
    input logic                  in_access,
    input logic                  psel_drop,
    input logic                  ctrl_diff,
    input logic [CNT_WIDTH-1:0]  wait_cnt
);

    a_enable_no_setup: assert property (@(posedge apb_clk) disable iff (!reset_n)
        (state == ST_IDLE) |-> !penable)
        else $error("APB enable without setup at %0t", $time);
    a_no_access: assert property (@(posedge apb_clk) disable iff (!reset_n)
        (state == ST_SETUP) |-> (psel && penable))
        else $error("APB setup not followed by access at %0t", $time);
    a_ctrl_change: assert property (@(posedge apb_clk) disable iff (!reset_n)
        (in_access || psel_drop) |-> !ctrl_diff)
        else $error("APB control change during access at %0t", $time);
    a_psel_drop: assert property (@(posedge apb_clk) disable iff (!reset_n)
        (state == ST_ACCESS) |-> psel)
        else $error("APB psel dropped before pready at %0t", $time);
    a_timeout: assert property (@(posedge apb_clk) disable iff (!reset_n)
        (in_access && !pready) |-> (wait_cnt != TIMEOUT_CNT))
        else $error("APB wait-state timeout at %0t", $time);
    a_prdata_stable: assert property (@(posedge apb_clk) disable iff (!reset_n)
        (psel && penable && pready) ##1 (psel && penable && pready) |-> $stable(prdata))
        else $error("APB prdata unstable while held ready at %0t", $time);

endmodule
`endif

// File: tb/tb_apb_protocol_monitor.sv
// Directed self-checking bench for apb_protocol_monitor (TIMEOUT=4, 4-bit counters).
module tb_apb_protocol_monitor;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 4;
    localparam int CW = 4;

    logic          apb_clk;
    logic          reset_n, psel, penable, pwrite, pready, pslverr, err_clr;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata, prdata;
    logic          err_valid;
    logic [2:0]    err_code;
    logic [5:0]    err_sticky;
    logic [CW-1:0] xfer_cnt, err_cnt, wait_max;

    int checks = 0;
    int errors = 0;

    apb_protocol_monitor #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO), .CNT_WIDTH(CW)) dut (
        .apb_clk(apb_clk), .reset_n(reset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pready(pready), .pslverr(pslverr), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
        .err_clr(err_clr), .err_valid(err_valid), .err_code(err_code), .err_sticky(err_sticky),
        .xfer_cnt(xfer_cnt), .err_cnt(err_cnt), .wait_max(wait_max)
    );

    initial apb_clk = 1'b0;
    always #5 apb_clk = ~apb_clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge apb_clk);
        #1;
    endtask

    task automatic bus_idle();
        psel = 1'b0; penable = 1'b0; pready = 1'b0; pslverr = 1'b0;
    endtask

    task automatic bus_setup(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
        psel = 1'b1; penable = 1'b0; pready = 1'b0; pslverr = 1'b0;
        paddr = a; pwrite = w; pwdata = d;
    endtask

    task automatic bus_access(input logic rdy, input logic serr);
        psel = 1'b1; penable = 1'b1; pready = rdy; pslverr = serr;
    endtask

    task automatic clr_pulse();
        bus_idle(); err_clr = 1'b1; tick(); err_clr = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; err_clr = 1'b0; bus_idle();
        paddr = 8'h00; pwrite = 1'b0; pwdata = 8'h00; prdata = 8'h5A;
        tick(); tick();
        reset_n = 1'b1; tick();
        chk("rst_valid", 16'(err_valid), 16'h0000);
        chk("rst_code", 16'(err_code), 16'h0000);
        chk("rst_sticky", 16'(err_sticky), 16'h0000);
        chk("rst_xfer", 16'(xfer_cnt), 16'h0000);
        chk("rst_errcnt", 16'(err_cnt), 16'h0000);
        chk("rst_waitmax", 16'(wait_max), 16'h0000);

        // Clean zero-wait write
        bus_setup(8'h04, 1'b1, 8'hA5); tick();
        chk("wr_setup_valid", 16'(err_valid), 16'h0000);
        bus_access(1'b1, 1'b0); tick();
        chk("wr_xfer", 16'(xfer_cnt), 16'h0001);
        chk("wr_sticky", 16'(err_sticky), 16'h0000);
        chk("wr_waitmax", 16'(wait_max), 16'h0000);
        chk("wr_valid", 16'(err_valid), 16'h0000);
        bus_idle(); tick();

        // Read with three wait states
        bus_setup(8'h08, 1'b0, 8'h00); tick();
        for (int i = 0; i < 3; i++) begin
            bus_access(1'b0, 1'b0); tick();
        end
        chk("rd3_wait_valid", 16'(err_valid), 16'h0000);
        bus_access(1'b1, 1'b0); tick();
        chk("rd3_waitmax", 16'(wait_max), 16'h0003);
        chk("rd3_xfer", 16'(xfer_cnt), 16'h0002);
        chk("rd3_errcnt", 16'(err_cnt), 16'h0000);
        bus_idle(); tick();

        // Five waits with TIMEOUT=4: single pulse on the fourth wait
        bus_setup(8'h0C, 1'b0, 8'h00); tick();
        for (int i = 0; i < 3; i++) begin
            bus_access(1'b0, 1'b0); tick();
        end
        chk("to_before_valid", 16'(err_valid), 16'h0000);
        bus_access(1'b0, 1'b0); tick();
        chk("to_valid", 16'(err_valid), 16'h0001);
        chk("to_code", 16'(err_code), 16'h0005);
        bus_access(1'b0, 1'b0); tick();
        chk("to_once_valid", 16'(err_valid), 16'h0000);
        bus_access(1'b1, 1'b0); tick();
        chk("to_sticky", 16'(err_sticky), 16'h0010);
        chk("to_errcnt", 16'(err_cnt), 16'h0001);
        chk("to_xfer", 16'(xfer_cnt), 16'h0003);
        chk("to_waitmax", 16'(wait_max), 16'h0005);
        bus_idle(); tick();

        clr_pulse();
        chk("clr1_sticky", 16'(err_sticky), 16'h0000);
        chk("clr1_errcnt", 16'(err_cnt), 16'h0000);
        chk("clr1_xfer", 16'(xfer_cnt), 16'h0000);
        chk("clr1_waitmax", 16'(wait_max), 16'h0000);

        // Code 1: penable without psel in IDLE
        psel = 1'b0; penable = 1'b1; tick();
        chk("c1_valid", 16'(err_valid), 16'h0001);
        chk("c1_code", 16'(err_code), 16'h0001);
        chk("c1_sticky", 16'(err_sticky), 16'h0001);
        chk("c1_errcnt", 16'(err_cnt), 16'h0001);
        bus_idle(); tick();
        chk("c1_pulse_end", 16'(err_valid), 16'h0000);

        // Code 2: setup followed by penable low
        bus_setup(8'h10, 1'b1, 8'h3C); tick();
        bus_idle(); tick();
        chk("c2_valid", 16'(err_valid), 16'h0001);
        chk("c2_code", 16'(err_code), 16'h0002);
        chk("c2_sticky", 16'(err_sticky), 16'h0003);
        chk("c2_errcnt", 16'(err_cnt), 16'h0002);
        bus_idle(); tick();
        clr_pulse();

        // Codes 3 and 4 together: paddr changes as psel drops mid-ACCESS
        bus_setup(8'h04, 1'b1, 8'h11); tick();
        bus_access(1'b0, 1'b0); tick();
        psel = 1'b0; penable = 1'b0; paddr = 8'h08; tick();
        chk("c34_valid", 16'(err_valid), 16'h0001);
        chk("c34_code", 16'(err_code), 16'h0003);
        chk("c34_sticky", 16'(err_sticky), 16'h000C);
        chk("c34_errcnt", 16'(err_cnt), 16'h0001);
        bus_idle(); tick();
        chk("c34_pulse_end", 16'(err_valid), 16'h0000);

        // Code 6: slave error still counts as a completed transfer
        bus_setup(8'h20, 1'b0, 8'h00); tick();
        bus_access(1'b1, 1'b1); tick();
        chk("c6_valid", 16'(err_valid), 16'h0001);
        chk("c6_code", 16'(err_code), 16'h0006);
        chk("c6_xfer", 16'(xfer_cnt), 16'h0001);
        chk("c6_sticky", 16'(err_sticky), 16'h002C);
        chk("c6_errcnt", 16'(err_cnt), 16'h0002);
        bus_idle(); tick();
        clr_pulse();
        chk("clr2_sticky", 16'(err_sticky), 16'h0000);
        chk("clr2_errcnt", 16'(err_cnt), 16'h0000);
        chk("clr2_xfer", 16'(xfer_cnt), 16'h0000);
        chk("clr2_waitmax", 16'(wait_max), 16'h0000);

        // Clear and violation in the same cycle
        err_clr = 1'b1; psel = 1'b0; penable = 1'b1; tick();
        chk("clrv_valid", 16'(err_valid), 16'h0001);
        chk("clrv_code", 16'(err_code), 16'h0001);
        chk("clrv_sticky", 16'(err_sticky), 16'h0001);
        chk("clrv_errcnt", 16'(err_cnt), 16'h0000);
        err_clr = 1'b0; bus_idle(); tick();

        // Repeated setup recaptures; following access with new address is clean
        bus_setup(8'h30, 1'b1, 8'h77); tick();
        bus_setup(8'h31, 1'b1, 8'h78); tick();
        chk("recap_code", 16'(err_code), 16'h0002);
        chk("recap_errcnt", 16'(err_cnt), 16'h0001);
        bus_access(1'b1, 1'b0); tick();
        chk("recap_valid", 16'(err_valid), 16'h0000);
        chk("recap_xfer", 16'(xfer_cnt), 16'h0001);
        bus_idle(); tick();

        // Back-to-back transfers
        bus_setup(8'h40, 1'b1, 8'h01); tick();
        bus_access(1'b1, 1'b0); tick();
        bus_setup(8'h44, 1'b0, 8'h00); tick();
        chk("b2b_setup_valid", 16'(err_valid), 16'h0000);
        chk("b2b_xfer1", 16'(xfer_cnt), 16'h0002);
        bus_access(1'b1, 1'b0); tick();
        chk("b2b_xfer2", 16'(xfer_cnt), 16'h0003);
        chk("b2b_valid", 16'(err_valid), 16'h0000);
        bus_idle(); tick();

        // Reset in ACCESS with pready low, then a clean transfer
        bus_setup(8'h04, 1'b1, 8'hA5); tick();
        bus_access(1'b0, 1'b0); tick();
        reset_n = 1'b0; tick();
        chk("mrst_valid", 16'(err_valid), 16'h0000);
        chk("mrst_sticky", 16'(err_sticky), 16'h0000);
        chk("mrst_xfer", 16'(xfer_cnt), 16'h0000);
        chk("mrst_errcnt", 16'(err_cnt), 16'h0000);
        bus_idle(); tick();
        reset_n = 1'b1; tick();
        chk("mrst_release_valid", 16'(err_valid), 16'h0000);
        bus_setup(8'h04, 1'b1, 8'hA5); tick();
        bus_access(1'b1, 1'b0); tick();
        chk("mrst_xfer_after", 16'(xfer_cnt), 16'h0001);
        chk("mrst_sticky_after", 16'(err_sticky), 16'h0000);
        chk("mrst_errcnt_after", 16'(err_cnt), 16'h0000);
        bus_idle(); tick();

        // Error counter saturates at all-ones
        for (int i = 0; i < 17; i++) begin
            psel = 1'b0; penable = 1'b1; tick();
        end
        chk("sat_errcnt", 16'(err_cnt), 16'h000F);
        chk("sat_sticky", 16'(err_sticky), 16'h0001);
        bus_idle(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
